// File: rtl/alu_serial_frame_rx.sv
// Serial deframer for the ALU command link: 11-bit packets carry B/A operand bytes
// and a closing CTL packet with op and CRC-4; one registered result per frame.
module alu_serial_frame_rx #(
  parameter int DATA_PKTS = 8,
  parameter int CHECK_OP  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        frame_valid,
  output logic [31:0] b_data,
  output logic [31:0] a_data,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op,
  output logic        busy
);

  // state   | meaning
  // IDLE    | line idle, waiting for a start bit (sin=0)
  // TYPE    | sampling the packet type bit
  // PAYLOAD | shifting in 8 payload bits, MSB first
  // STOP    | sampling the stop bit; accept packet or abort
  // ABORT   | framing error seen, waiting for one high cycle
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TYPE    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_STOP    = 3'd3,
    S_ABORT   = 3'd4
  } state_t;

  localparam logic [3:0] DATA_PKTS_C = 4'(DATA_PKTS);

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        type_q, type_d;
  logic [7:0]  pay_q, pay_d;
  logic [3:0]  pkt_cnt_q, pkt_cnt_d;
  logic [63:0] ba_q, ba_d;
  logic        fv_q, fv_d;
  logic [31:0] b_data_q, b_data_d;
  logic [31:0] a_data_q, a_data_d;
  logic [2:0]  op_q, op_d;
  logic        err_data_q, err_data_d;
  logic        err_crc_q, err_crc_d;
  logic        err_op_q, err_op_d;
  logic        busy_q, busy_d;

  logic [3:0]  crc_calc;
  logic        op_known;

  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // CTL payload is {0, op[2:0], crc[3:0]}, so op sits in pay_q[6:4]
  assign crc_calc = crc4({ba_q, 1'b1, pay_q[6:4]});
  assign op_known = (pay_q[5] == 1'b0);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    type_d     = type_q;
    pay_d      = pay_q;
    pkt_cnt_d  = pkt_cnt_q;
    ba_d       = ba_q;
    fv_d       = 1'b0;
    b_data_d   = b_data_q;
    a_data_d   = a_data_q;
    op_d       = op_q;
    err_data_d = err_data_q;
    err_crc_d  = err_crc_q;
    err_op_d   = err_op_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (!sin) begin
          state_d = S_TYPE;
          busy_d  = 1'b1;
        end
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        pay_d     = {pay_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sin) begin
          state_d = S_IDLE;
          if (!type_q) begin
            ba_d = {ba_q[55:0], pay_q};
            if (pkt_cnt_q != 4'hF) begin
              pkt_cnt_d = pkt_cnt_q + 4'd1;
            end
          end else begin
            fv_d       = 1'b1;
            busy_d     = 1'b0;
            pkt_cnt_d  = 4'd0;
            b_data_d   = ba_q[63:32];
            a_data_d   = ba_q[31:0];
            op_d       = pay_q[6:4];
            err_data_d = 1'b0;
            err_crc_d  = 1'b0;
            err_op_d   = 1'b0;
            if (pkt_cnt_q != DATA_PKTS_C) begin
              err_data_d = 1'b1;
            end else if (pay_q[3:0] != crc_calc) begin
              err_crc_d = 1'b1;
            end else if ((CHECK_OP != 0) && !op_known) begin
              err_op_d = 1'b1;
            end
          end
        end else begin
          // framing error: report it now, then hold off until the line goes high
          state_d    = S_ABORT;
          fv_d       = 1'b1;
          busy_d     = 1'b0;
          pkt_cnt_d  = 4'd0;
          b_data_d   = ba_q[63:32];
          a_data_d   = ba_q[31:0];
          op_d       = 3'd0;
          err_data_d = 1'b1;
          err_crc_d  = 1'b0;
          err_op_d   = 1'b0;
        end
      end
      S_ABORT: begin
        if (sin) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      type_q     <= 1'b0;
      pay_q      <= 8'd0;
      pkt_cnt_q  <= 4'd0;
      ba_q       <= 64'd0;
      fv_q       <= 1'b0;
      b_data_q   <= 32'd0;
      a_data_q   <= 32'd0;
      op_q       <= 3'd0;
      err_data_q <= 1'b0;
      err_crc_q  <= 1'b0;
      err_op_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      type_q     <= type_d;
      pay_q      <= pay_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ba_q       <= ba_d;
      fv_q       <= fv_d;
      b_data_q   <= b_data_d;
      a_data_q   <= a_data_d;
      op_q       <= op_d;
      err_data_q <= err_data_d;
      err_crc_q  <= err_crc_d;
      err_op_q   <= err_op_d;
      busy_q     <= busy_d;
    end
  end

  assign frame_valid = fv_q;
  assign b_data      = b_data_q;
  assign a_data      = a_data_q;
  assign op          = op_q;
  assign err_data    = err_data_q;
  assign err_crc     = err_crc_q;
  assign err_op      = err_op_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_serial_frame_rx.sv
// Directed bench for alu_serial_frame_rx: two instances (op check on/off) share one line;
// a frame-level model predicts every result and a per-cycle compare checks them.
module tb_alu_serial_frame_rx;

  logic clk, rst, sin;

  logic        fv0, ed0, ec0, eo0, busy0;
  logic [31:0] b0, a0;
  logic [2:0]  op0;
  logic        fv1, ed1, ec1, eo1, busy1;
  logic [31:0] b1, a1;
  logic [2:0]  op1;

  alu_serial_frame_rx #(.DATA_PKTS(8), .CHECK_OP(1)) dut0 (
    .clk(clk), .rst(rst), .sin(sin), .frame_valid(fv0), .b_data(b0), .a_data(a0),
    .op(op0), .err_data(ed0), .err_crc(ec0), .err_op(eo0), .busy(busy0));

  alu_serial_frame_rx #(.DATA_PKTS(8), .CHECK_OP(0)) dut1 (
    .clk(clk), .rst(rst), .sin(sin), .frame_valid(fv1), .b_data(b1), .a_data(a1),
    .op(op1), .err_data(ed1), .err_crc(ec1), .err_op(eo1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic        ed;
    logic        ec;
    logic        eo;
    logic        chk;
  } exp_t;

  exp_t       expq[$];
  exp_t       last;
  logic [7:0] hist[$];
  int         cnt;
  logic       prev_fv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // CRC as polynomial remainder of msg*x^4 modulo x^4+x+1
  function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a,
                                          input logic [2:0] o);
    logic [71:0] r;
    r = {b, a, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(8'h00);
    expq.delete();
    cnt       = 0;
    last.b    = '0;
    last.a    = '0;
    last.op   = '0;
    last.ed   = 1'b0;
    last.ec   = 1'b0;
    last.eo   = 1'b0;
    last.chk  = 1'b1;
    prev_fv   = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("fv_match", {63'd0, fv1}, {63'd0, fv0});
    if (fv0) begin
      if (prev_fv) chk("fv_consecutive", 64'd1, 64'd0);
      if (expq.size() == 0) begin
        chk("fv_unexpected", 64'd1, 64'd0);
      end else begin
        e    = expq.pop_front();
        last = e;
      end
    end
    if (last.chk) begin
      chk("b0", {32'd0, b0}, {32'd0, last.b});
      chk("a0", {32'd0, a0}, {32'd0, last.a});
      chk("op0", {61'd0, op0}, {61'd0, last.op});
      chk("b1", {32'd0, b1}, {32'd0, last.b});
      chk("a1", {32'd0, a1}, {32'd0, last.a});
      chk("op1", {61'd0, op1}, {61'd0, last.op});
    end
    chk("err_data0", {63'd0, ed0}, {63'd0, last.ed});
    chk("err_crc0", {63'd0, ec0}, {63'd0, last.ec});
    chk("err_op0", {63'd0, eo0}, {63'd0, last.eo});
    chk("err_data1", {63'd0, ed1}, {63'd0, last.ed});
    chk("err_crc1", {63'd0, ec1}, {63'd0, last.ec});
    chk("err_op1", {63'd0, eo1}, 64'd0);
    prev_fv = fv0;
  end

  task automatic bit_out(input logic v);
    sin = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] pay, input logic stopb);
    bit_out(1'b0);
    bit_out(typ);
    for (int i = 7; i >= 0; i--) bit_out(pay[i]);
    bit_out(stopb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bit_out(1'b1);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_pkt(1'b0, d, 1'b1);
    hist.push_back(d);
    void'(hist.pop_front());
    cnt++;
  endtask

  task automatic send_ctl(input logic [2:0] o, input logic [3:0] crc);
    exp_t e;
    e.b   = {hist[0], hist[1], hist[2], hist[3]};
    e.a   = {hist[4], hist[5], hist[6], hist[7]};
    e.op  = o;
    e.ed  = (cnt != 8);
    e.ec  = !e.ed && (crc != crc_model(e.b, e.a, o));
    e.eo  = !e.ed && !e.ec && !(o == 3'd0 || o == 3'd1 || o == 3'd4 || o == 3'd5);
    e.chk = 1'b1;
    expq.push_back(e);
    cnt = 0;
    send_pkt(1'b1, {1'b0, o, crc}, 1'b1);
    chk("fv_after_ctl_stop", {63'd0, fv0}, 64'd1);
    chk("busy_at_fv", {63'd0, busy0}, 64'd0);
  endtask

  task automatic send_bad(input logic typ, input logic [7:0] d);
    exp_t e;
    e.b   = '0;
    e.a   = '0;
    e.op  = '0;
    e.ed  = 1'b1;
    e.ec  = 1'b0;
    e.eo  = 1'b0;
    e.chk = 1'b0;
    expq.push_back(e);
    cnt = 0;
    send_pkt(typ, d, 1'b0);
    chk("fv_after_abort", {63'd0, fv0}, 64'd1);
    chk("busy_after_abort", {63'd0, busy0}, 64'd0);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a,
                            input logic [2:0] o, input logic [3:0] crc);
    for (int i = 3; i >= 0; i--) send_data(b[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_data(a[i*8 +: 8]);
    send_ctl(o, crc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    sin = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // model pins
    chk("crc_pin_op000", {60'd0, crc_model(32'd0, 32'd0, 3'b000)}, 64'hB);
    chk("crc_pin_op100", {60'd0, crc_model(32'd0, 32'd0, 3'b100)}, 64'h7);
    chk("crc_pin_op111", {60'd0, crc_model(32'd0, 32'd0, 3'b111)}, 64'h2);

    // minimal 99-bit frame, all zero, literal CRC
    send_data(8'h00);
    chk("busy_mid_frame", {63'd0, busy0}, 64'd1);
    for (int i = 0; i < 7; i++) send_data(8'h00);
    send_ctl(3'b000, 4'hB);
    chk("lit_no_err", {61'd0, ed0, ec0, eo0}, 64'd0);

    // op=100 good, then bad CRC, back to back
    send_frame(32'd0, 32'd0, 3'b100, 4'h7);
    chk("lit_op100", {61'd0, op0}, 64'd4);
    send_frame(32'd0, 32'd0, 3'b100, 4'h8);
    chk("lit_err_crc", {61'd0, ed0, ec0, eo0}, 64'b010);
    idle(2);

    // first DATA packet replaced by idle ones: only 7 DATA
    idle(11);
    for (int i = 0; i < 7; i++) send_data(8'h00);
    send_ctl(3'b000, 4'hB);
    chk("lit_err_data", {61'd0, ed0, ec0, eo0}, 64'b100);

    // unknown op with correct CRC
    send_frame(32'd0, 32'd0, 3'b111, 4'h2);
    chk("lit_err_op_chk1", {61'd0, ed0, ec0, eo0}, 64'b001);
    chk("lit_err_op_chk0", {61'd0, ed1, ec1, eo1}, 64'b000);
    idle(1);

    // nontrivial payload
    send_frame(32'hA5C3_0F81, 32'h7E00_FF19, 3'b101,
               crc_model(32'hA5C3_0F81, 32'h7E00_FF19, 3'b101));

    // framing error on 3rd DATA packet, then a clean frame
    send_data(8'h11);
    send_data(8'h22);
    send_bad(1'b0, 8'h33);
    idle(2);
    send_frame(32'hFFFF_FFFF, 32'h1234_5678, 3'b001,
               crc_model(32'hFFFF_FFFF, 32'h1234_5678, 3'b001));
    chk("lit_b_ff", {32'd0, b0}, {32'd0, 32'hFFFF_FFFF});
    chk("lit_a_1234", {32'd0, a0}, {32'd0, 32'h1234_5678});
    idle(2);

    // nine DATA packets before CTL
    for (int i = 0; i < 9; i++) send_data(8'(i + 1));
    send_ctl(3'b000, 4'h0);
    idle(1);

    // reset in the middle of the 5th DATA packet
    for (int i = 0; i < 4; i++) send_data(8'hC0 + 8'(i));
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    rst = 1'b1;
    model_reset();
    idle(2);
    rst = 1'b0;
    chk("rst_b_zero", {32'd0, b0}, 64'd0);
    chk("rst_flags_zero", {60'd0, fv0, ed0, ec0, eo0}, 64'd0);
    chk("rst_busy_zero", {63'd0, busy0}, 64'd0);
    idle(2);
    send_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b000,
               crc_model(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b000));

    idle(5);
    chk("expq_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
